// File: rtl/serv_fetch.sv
// Instruction fetch unit: one bus read per accepted fetch, with flush/drain handling.
// Optional misaligned-PC trap is enabled by defining SERV_FETCH_ALIGN_CHECK_EN.
module serv_fetch #(
  parameter int AW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_fetch,
  input  logic [AW-1:0] i_pc,
  input  logic          i_flush,
  output logic [AW-1:0] o_ibus_adr,
  output logic          o_ibus_cyc,
  input  logic [31:0]   i_ibus_rdt,
  input  logic          i_ibus_ack,
  output logic          o_wb_en,
  output logic [29:0]   o_wb_rdt,
  output logic          o_illegal,
  output logic          o_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUS     = 2'd1,
    DELIVER = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam logic [AW-1:0] ADR_MASK = ~AW'(3);

  state_t        state_q, state_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [29:0]   rdt_q, rdt_d;
  logic          illegal_q, illegal_d;

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    rdt_d     = rdt_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        // A simultaneous flush cancels the request outright.
        if (i_fetch && !i_flush) begin
          adr_d   = i_pc;
          state_d = BUS;
`ifdef SERV_FETCH_ALIGN_CHECK_EN
          if (i_pc[1:0] != 2'b00) begin
            state_d   = DELIVER;
            illegal_d = 1'b1;
          end
`endif
        end
      end
      BUS: begin
        if (i_ibus_ack) begin
          if (i_flush) begin
            state_d = IDLE;
          end else begin
            rdt_d     = i_ibus_rdt[31:2];
            illegal_d = (i_ibus_rdt[1:0] != 2'b11);
            state_d   = DELIVER;
          end
        end else if (i_flush) begin
          // The bus cycle cannot be abandoned; wait out the ack and drop the data.
          state_d = DRAIN;
        end
      end
      DELIVER: state_d = IDLE;
      DRAIN: begin
        if (i_ibus_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Address and instruction data carry no reset: they are only consumed when qualified.
  always_ff @(posedge i_clk) begin
    adr_q <= adr_d;
    rdt_q <= rdt_d;
  end

  assign o_ibus_adr = adr_q & ADR_MASK;
  assign o_ibus_cyc = (state_q == BUS) || (state_q == DRAIN);
  assign o_wb_en    = (state_q == DELIVER) && !i_flush;
  assign o_wb_rdt   = rdt_q;
  assign o_illegal  = illegal_q;
  assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_serv_fetch.sv
// Scoreboard bench for serv_fetch: expected deliveries are queued at ack time
// and compared whenever the DUT pulses o_wb_en.
module tb_serv_fetch;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_fetch = 1'b0;
  logic [31:0] i_pc = '0;
  logic        i_flush = 1'b0;
  logic [31:0] o_ibus_adr;
  logic        o_ibus_cyc;
  logic [31:0] i_ibus_rdt = '0;
  logic        i_ibus_ack = 1'b0;
  logic        o_wb_en;
  logic [29:0] o_wb_rdt;
  logic        o_illegal;
  logic        o_busy;

  serv_fetch #(.AW(32)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_fetch    (i_fetch),
    .i_pc       (i_pc),
    .i_flush    (i_flush),
    .o_ibus_adr (o_ibus_adr),
    .o_ibus_cyc (o_ibus_cyc),
    .i_ibus_rdt (i_ibus_rdt),
    .i_ibus_ack (i_ibus_ack),
    .o_wb_en    (o_wb_en),
    .o_wb_rdt   (o_wb_rdt),
    .o_illegal  (o_illegal),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [29:0] rdt;
    logic        ill;
  } exp_t;

  exp_t        exp_q[$];
  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          wb_cnt  = 0;
  int          exp_wb  = 0;
  logic [29:0] last_cap = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  always @(negedge i_clk) begin
    if (!i_rst && o_wb_en) begin
      wb_cnt++;
      if (exp_q.size() == 0) begin
        check("wb_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wb_rdt", {2'b00, o_wb_rdt}, {2'b00, e.rdt});
        check("wb_ill", {31'd0, o_illegal}, {31'd0, e.ill});
        $display("wb delivered rdt=%08h ill=%0d", o_wb_rdt, o_illegal);
      end
    end
  end

  // Full fetch: request, wait cycles, ack, delivery. poke re-pulses i_fetch while on the bus.
  task automatic fetch_txn(input logic [31:0] pc, input logic [31:0] rdt,
                           input int wait_cyc, input bit poke);
    logic [31:0] exp_adr;
    exp_adr = pc & 32'hFFFF_FFFC;
    i_fetch = 1'b1;
    i_pc    = pc;
    tick();
    i_fetch = 1'b0;
    for (int k = 0; k < wait_cyc; k++) begin
      check("bus_cyc", {31'd0, o_ibus_cyc}, 32'd1);
      check("bus_adr", o_ibus_adr, exp_adr);
      if (poke) begin
        i_fetch = 1'b1;
        i_pc    = pc + 32'h40;
      end
      tick();
      i_fetch = 1'b0;
    end
    check("ack_cyc", {31'd0, o_ibus_cyc}, 32'd1);
    check("ack_adr", o_ibus_adr, exp_adr);
    i_ibus_ack = 1'b1;
    i_ibus_rdt = rdt;
    exp_q.push_back('{rdt: rdt[31:2], ill: (rdt[1:0] != 2'b11)});
    exp_wb++;
    last_cap = rdt[31:2];
    tick();
    i_ibus_ack = 1'b0;
    i_ibus_rdt = $urandom;
    check("dlv_cyc", {31'd0, o_ibus_cyc}, 32'd0);
    check("dlv_wben", {31'd0, o_wb_en}, 32'd1);
    tick();
    check("idle_wben", {31'd0, o_wb_en}, 32'd0);
    check("idle_busy", {31'd0, o_busy}, 32'd0);
    $display("fetch pc=%08h rdt=%08h wait=%0d poke=%0d", pc, rdt, wait_cyc, poke);
  endtask

  initial begin
    tick();
    tick();
    check("rst_cyc", {31'd0, o_ibus_cyc}, 32'd0);
    check("rst_wben", {31'd0, o_wb_en}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_ill", {31'd0, o_illegal}, 32'd0);
    i_rst = 1'b0;
    tick();

    // Minimum-latency fetch, then a slow ack with an illegal (zero) word.
    fetch_txn(32'h100, 32'h00500093, 0, 1'b0);
    fetch_txn(32'h200, 32'h00000000, 5, 1'b0);

    // Extra fetch requests while on the bus must not start another cycle.
    fetch_txn(32'h300, 32'h12345677, 3, 1'b1);

    // Ack outside a bus cycle is ignored.
    i_ibus_ack = 1'b1;
    i_ibus_rdt = 32'hDEADBEEF;
    tick();
    i_ibus_ack = 1'b0;
    check("stray_ack_busy", {31'd0, o_busy}, 32'd0);
    check("stray_ack_wben", {31'd0, o_wb_en}, 32'd0);
    $display("stray ack in idle");

    // Flush at wait cycle 2, ack at cycle 4: bus held, data dropped.
    i_fetch = 1'b1;
    i_pc    = 32'h400;
    tick();
    i_fetch = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("drain_cyc", {31'd0, o_ibus_cyc}, 32'd1);
      check("drain_adr", o_ibus_adr, 32'h400);
      i_flush = (k == 2);
      tick();
    end
    i_flush = 1'b0;
    check("drain_cyc4", {31'd0, o_ibus_cyc}, 32'd1);
    i_ibus_ack = 1'b1;
    i_ibus_rdt = 32'hAAAA_AAAB;
    tick();
    i_ibus_ack = 1'b0;
    check("drain_done_cyc", {31'd0, o_ibus_cyc}, 32'd0);
    check("drain_done_busy", {31'd0, o_busy}, 32'd0);
    check("drain_done_wben", {31'd0, o_wb_en}, 32'd0);
    $display("flush during bus, drained");

    // Flush coincident with ack.
    i_fetch = 1'b1;
    i_pc    = 32'h500;
    tick();
    i_fetch    = 1'b0;
    i_flush    = 1'b1;
    i_ibus_ack = 1'b1;
    i_ibus_rdt = 32'h5555_5557;
    tick();
    i_flush    = 1'b0;
    i_ibus_ack = 1'b0;
    check("flack_busy", {31'd0, o_busy}, 32'd0);
    check("flack_wben", {31'd0, o_wb_en}, 32'd0);
    $display("flush with ack");

    // Flush during delivery suppresses the pulse; data was still captured.
    i_fetch = 1'b1;
    i_pc    = 32'h600;
    tick();
    i_fetch    = 1'b0;
    i_ibus_ack = 1'b1;
    i_ibus_rdt = 32'h0C0F_FEE3;
    last_cap   = 30'h0303_FFB8;
    tick();
    i_ibus_ack = 1'b0;
    i_flush    = 1'b1;
    #1;
    check("fldlv_wben", {31'd0, o_wb_en}, 32'd0);
    tick();
    i_flush = 1'b0;
    check("fldlv_busy", {31'd0, o_busy}, 32'd0);
    check("fldlv_rdt", {2'b00, o_wb_rdt}, {2'b00, last_cap});
    $display("flush in deliver");

    // Flush and fetch together in idle: no fetch.
    i_fetch = 1'b1;
    i_flush = 1'b1;
    i_pc    = 32'h700;
    tick();
    i_fetch = 1'b0;
    i_flush = 1'b0;
    check("flfetch_busy", {31'd0, o_busy}, 32'd0);
    check("flfetch_cyc", {31'd0, o_ibus_cyc}, 32'd0);
    $display("flush+fetch in idle");

    // Reset mid-bus, then a stray ack.
    i_fetch = 1'b1;
    i_pc    = 32'h800;
    tick();
    i_fetch = 1'b0;
    check("rstbus_cyc_pre", {31'd0, o_ibus_cyc}, 32'd1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("rstbus_cyc", {31'd0, o_ibus_cyc}, 32'd0);
    check("rstbus_busy", {31'd0, o_busy}, 32'd0);
    check("rstbus_ill", {31'd0, o_illegal}, 32'd0);
    i_ibus_ack = 1'b1;
    i_ibus_rdt = 32'h1111_1113;
    tick();
    i_ibus_ack = 1'b0;
    check("rstack_wben", {31'd0, o_wb_en}, 32'd0);
    check("rstack_busy", {31'd0, o_busy}, 32'd0);
    tick();
    check("rstack_wben2", {31'd0, o_wb_en}, 32'd0);
    $display("reset mid-bus with stray ack");

    // Misaligned PC.
`ifdef SERV_FETCH_ALIGN_CHECK_EN
    i_fetch = 1'b1;
    i_pc    = 32'h102;
    exp_q.push_back('{rdt: last_cap, ill: 1'b1});
    exp_wb++;
    tick();
    i_fetch = 1'b0;
    check("align_cyc", {31'd0, o_ibus_cyc}, 32'd0);
    check("align_wben", {31'd0, o_wb_en}, 32'd1);
    tick();
    check("align_busy", {31'd0, o_busy}, 32'd0);
    check("align_cyc2", {31'd0, o_ibus_cyc}, 32'd0);
    $display("misaligned pc trapped");
`else
    fetch_txn(32'h102, 32'h00A00113, 1, 1'b0);
`endif

    // Randomised fetches.
    for (int n = 0; n < 12; n++) begin
      fetch_txn($urandom & 32'h0000_FFFF, $urandom, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    tick();
    tick();
    check("q_empty", exp_q.size(), 32'd0);
    check("wb_count", wb_cnt, exp_wb);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/serv_fetch.md
SERV_FETCH -- requirements
Module: serv_fetch

Interface
REQ-001 SHALL have parameter AW, default 32: instruction bus address width, 3..32.
REQ-002 SHALL have port i_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_fetch  in  1  one-cycle request to fetch the instruction at i_pc.
REQ-005 SHALL have port i_pc  in  AW  fetch address, sampled only in the cycle i_fetch is accepted.
REQ-006 SHALL have port i_flush  in  1  discard any in-flight fetch.
REQ-007 SHALL have port o_ibus_adr  out  AW  bus address, bits [1:0] forced to 0.
REQ-008 SHALL have port o_ibus_cyc  out  1  bus cycle/strobe.
REQ-009 SHALL have port i_ibus_rdt  in  32  bus read data.
REQ-010 SHALL have port i_ibus_ack  in  1  bus acknowledge, valid only while o_ibus_cyc=1.
REQ-011 SHALL have port o_wb_en  out  1  one-cycle pulse: o_wb_rdt valid, load decoder/immediate stage.
REQ-012 SHALL have port o_wb_rdt  out  30  captured instruction bits [31:2].
REQ-013 SHALL have port o_illegal  out  1  captured instruction bits [1:0] != 2'b11; valid with o_wb_en.
REQ-014 SHALL have port o_busy  out  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, BUS, DELIVER, DRAIN.
REQ-016 SHALL accept i_fetch only in IDLE; i_fetch in any other state is ignored.
REQ-017 SHALL on acceptance register i_pc into o_ibus_adr and enter BUS; o_ibus_cyc=1 from the next cycle.
REQ-018 SHALL hold o_ibus_cyc and o_ibus_adr stable in BUS until the cycle i_ibus_ack=1.
REQ-019 SHALL on ack in BUS capture i_ibus_rdt[31:2] into o_wb_rdt, set o_illegal from i_ibus_rdt[1:0], drop o_ibus_cyc next cycle, and enter DELIVER.
REQ-020 SHALL in DELIVER assert o_wb_en for exactly one cycle, then return to IDLE; minimum latency: fetch accepted at edge N, ack at N+1, o_wb_en at N+2.
REQ-021 SHALL hold o_wb_rdt and o_illegal constant from capture until the next capture.
REQ-022 SHALL on i_flush in BUS without ack enter DRAIN; on i_flush coincident with ack, discard data and go to IDLE with no o_wb_en.
REQ-023 SHALL in DRAIN keep o_ibus_cyc=1 until ack, discard data, then go to IDLE; no o_wb_en.
REQ-024 SHALL on i_flush in DELIVER suppress o_wb_en and go to IDLE.
REQ-025 SHALL ignore i_flush in IDLE; i_flush and i_fetch together in IDLE: flush wins, no fetch.
REQ-026 SHALL ignore i_ibus_ack when o_ibus_cyc=0.

Reset
REQ-027 SHALL on i_rst=1 at a clock edge enter IDLE regardless of state, including mid-BUS.
REQ-028 SHALL reset o_ibus_cyc=0, o_wb_en=0, o_busy=0, o_illegal=0; o_ibus_adr and o_wb_rdt are not reset.
REQ-029 SHALL treat an ack arriving during or after reset, with o_ibus_cyc=0, as ignored.

Configuration
REQ-030 SHALL, with SERV_FETCH_ALIGN_CHECK_EN defined, on an accepted i_fetch with i_pc[1:0]!=0, skip BUS, enter DELIVER with o_illegal=1 and o_wb_rdt unchanged, and pulse o_wb_en.
REQ-031 SHALL, without SERV_FETCH_ALIGN_CHECK_EN, ignore i_pc[1:0] and fetch normally.

Verification
REQ-032 i_fetch with i_pc=0x100, ack next cycle with rdt=0x00500093 -> o_ibus_adr=0x100, o_wb_en one cycle at N+2, o_wb_rdt=0x00500093>>2, o_illegal=0.
REQ-033 Ack delayed 5 cycles with rdt=0x00000000 -> o_ibus_cyc high 5 cycles, adr stable, then o_wb_en with o_illegal=1.
REQ-034 i_flush during BUS at wait cycle 2, ack at cycle 4 -> o_ibus_cyc held to ack, no o_wb_en, o_busy low after ack.
REQ-035 i_rst asserted mid-BUS -> next cycle o_ibus_cyc=0, o_busy=0; subsequent stray ack produces no o_wb_en.
REQ-036 SERV_FETCH_ALIGN_CHECK_EN defined, i_fetch with i_pc=0x102 -> o_ibus_cyc never asserted, o_wb_en with o_illegal=1; undefined -> bus fetch at o_ibus_adr=0x100.
REQ-037 i_fetch pulsed during BUS -> no second bus cycle, exactly one o_wb_en.
